// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, runs the req/ack handshake to instruction memory
// and feeds IF_pc_4/IF_inst (or the NOP bubble) to IF/ID. Optional macro: FETCH_BYPASS_EN.
module if_fetch_unit #(
  parameter int                 PC_W     = 9,
  parameter int                 INST_W   = 32,
  parameter logic [PC_W-1:0]    RESET_PC = '0,
  parameter logic [INST_W-1:0]  NOP      = 32'h0000_0020
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [PC_W-1:0]   IF_pc_4,
  output logic [INST_W-1:0] IF_inst,
  output logic              if_valid
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP, S_HOLD} state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PC_W-1:0]     addr_q, addr_d;
  logic [INST_W-1:0]   inst_q, inst_d;

  logic [PC_W-1:0]     target_pc;
  logic [PC_W-1:0]     pc_plus4;
  logic [PC_W-1:0]     addr_plus4;

  assign target_pc  = redirect_pc & ~PC_W'(3);
  assign pc_plus4   = pc_q + PC_W'(4);
  assign addr_plus4 = addr_q + PC_W'(4);
  assign imem_addr  = addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      inst_q  <= NOP;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    inst_d   = inst_q;
    imem_req = 1'b0;
    if_valid = 1'b0;
    IF_inst  = NOP;
    IF_pc_4  = '0;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        addr_d  = pc_q;
      end

      S_REQ: begin
        imem_req = 1'b1;
        if (redirect) begin
          pc_d = target_pc;
          // An un-acked request must keep its address, so wait out the stale response in S_DROP.
          if (imem_ack) begin
            addr_d = target_pc;
          end else begin
            state_d = S_DROP;
          end
        end else if (imem_ack) begin
`ifdef FETCH_BYPASS_EN
          if (!stall) begin
            if_valid = 1'b1;
            IF_inst  = imem_rdata;
            IF_pc_4  = addr_plus4;
            pc_d     = addr_plus4;
            addr_d   = addr_plus4;
          end else begin
            inst_d  = imem_rdata;
            state_d = S_HOLD;
          end
`else
          inst_d  = imem_rdata;
          state_d = S_HOLD;
`endif
        end
      end

      S_DROP: begin
        imem_req = 1'b1;
        if (redirect) begin
          pc_d = target_pc;
        end
        if (imem_ack) begin
          addr_d  = redirect ? target_pc : pc_q;
          state_d = S_REQ;
        end
      end

      S_HOLD: begin
        if_valid = 1'b1;
        IF_inst  = inst_q;
        IF_pc_4  = pc_plus4;
        if (redirect) begin
          pc_d    = target_pc;
          addr_d  = target_pc;
          inst_d  = NOP;
          state_d = S_REQ;
        end else if (!stall) begin
          pc_d    = pc_plus4;
          addr_d  = pc_plus4;
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: random stall/redirect/memory latency against a
// PC-sequence reference model, plus directed reset and first-fetch checks.
module tb_if_fetch_unit;

  localparam int          PC_W     = 9;
  localparam int          INST_W   = 32;
  localparam logic [8:0]  RESET_PC = 9'h000;
  localparam logic [31:0] NOP      = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [8:0]  redirect_pc = '0;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [8:0]  IF_pc_4;
  logic [31:0] IF_inst;
  logic        if_valid;

  int total = 0;
  int bad = 0;
  int delivered = 0;
  bit randLat = 1'b0;
  bit spurious = 1'b0;

  // expected address of the next instruction the fetch unit must present
  logic [8:0] expQ[$];

  bit         busy = 1'b0;
  logic [8:0] reqAddr = '0;
  int         waitCnt = 0;

  if_fetch_unit #(
    .PC_W(PC_W), .INST_W(INST_W), .RESET_PC(RESET_PC), .NOP(NOP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .IF_pc_4(IF_pc_4),
    .IF_inst(IF_inst), .if_valid(if_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memFn(input logic [8:0] a);
    logic [31:0] w;
    w = {23'h0, a};
    return 32'h8C00_0000 ^ (w * 32'h0001_0101) ^ (w << 20);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_imem_req", 32'(imem_req), 32'h0);
    checkOutput("rst_imem_addr", 32'(imem_addr), 32'(RESET_PC));
    checkOutput("rst_if_valid", 32'(if_valid), 32'h0);
    checkOutput("rst_IF_inst", IF_inst, NOP);
    checkOutput("rst_IF_pc_4", 32'(IF_pc_4), 32'h0);
  endtask

  task automatic applyStimulus(input bit doReset);
    if (doReset) begin
      stall = 1'b0;
      redirect = 1'b0;
      #2 rst_n = 1'b0;
      #1 checkResetOutputs();
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
    end else begin
      stall    = ($urandom_range(0, 99) < 30);
      redirect = ($urandom_range(0, 99) < 8);
      case ($urandom_range(0, 3))
        0:       redirect_pc = 9'h1FC;
        1:       redirect_pc = 9'h1FE;
        default: redirect_pc = 9'($urandom);
      endcase
    end
  endtask

  // instruction memory: variable latency, holds one outstanding request, checks address stability
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      busy = 1'b0;
      imem_ack = 1'b0;
    end else begin
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      if (imem_req) begin
        if (!busy) begin
          busy = 1'b1;
          reqAddr = imem_addr;
          waitCnt = randLat ? int'($urandom_range(0, 3)) : 0;
        end else begin
          checkOutput("addr_stable", 32'(imem_addr), 32'(reqAddr));
        end
        if (waitCnt == 0) begin
          imem_ack = 1'b1;
          imem_rdata = memFn(reqAddr);
          busy = 1'b0;
        end else begin
          waitCnt--;
        end
      end else if (spurious && ($urandom_range(0, 3) == 0)) begin
        imem_ack = 1'b1;
      end
    end
  end

  // monitor: compare presented instruction against the model, then advance the model
  always @(negedge clk) begin
    logic [8:0] nxt;
    if (!rst_n) begin
      expQ.delete();
      expQ.push_back(RESET_PC);
    end else begin
      if (if_valid) begin
        nxt = expQ[0] + 9'd4;
        checkOutput("IF_pc_4", 32'(IF_pc_4), 32'(nxt));
        checkOutput("IF_inst", IF_inst, memFn(expQ[0]));
      end else begin
        checkOutput("bubble_inst", IF_inst, NOP);
        checkOutput("bubble_pc_4", 32'(IF_pc_4), 32'h0);
      end
      if (redirect) begin
        expQ.delete();
        expQ.push_back(redirect_pc & 9'h1FC);
      end else if (if_valid && !stall) begin
        nxt = expQ.pop_front() + 9'd4;
        expQ.push_back(nxt);
        delivered++;
      end
    end
  end

  initial begin
    #11 checkResetOutputs();
    #1 rst_n = 1'b1;

    @(negedge clk);
    checkOutput("first_req", 32'(imem_req), 32'h1);
    checkOutput("first_addr", 32'(imem_addr), 32'h000);
`ifdef FETCH_BYPASS_EN
    checkOutput("byp_valid0", 32'(if_valid), 32'h1);
    checkOutput("byp_pc4_0", 32'(IF_pc_4), 32'h004);
    @(negedge clk);
    checkOutput("byp_valid1", 32'(if_valid), 32'h1);
    checkOutput("byp_pc4_1", 32'(IF_pc_4), 32'h008);
    @(negedge clk);
    checkOutput("byp_valid2", 32'(if_valid), 32'h1);
    checkOutput("byp_pc4_2", 32'(IF_pc_4), 32'h00C);
    checkOutput("byp_addr2", 32'(imem_addr), 32'h008);
`else
    checkOutput("first_valid", 32'(if_valid), 32'h0);
    @(negedge clk);
    checkOutput("hold_valid", 32'(if_valid), 32'h1);
    checkOutput("hold_pc4", 32'(IF_pc_4), 32'h004);
    checkOutput("hold_inst", IF_inst, memFn(9'h000));
    checkOutput("hold_req", 32'(imem_req), 32'h0);
    @(negedge clk);
    checkOutput("second_req", 32'(imem_req), 32'h1);
    checkOutput("second_addr", 32'(imem_addr), 32'h004);
`endif

    randLat = 1'b1;
    spurious = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      applyStimulus(c == 1500);
    end
    stall = 1'b0;
    redirect = 1'b0;
    @(negedge clk);
    checkOutput("progress", 32'(delivered > 100), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
